// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - execute stage: single-cycle ALU, iterative MULT/MULTU into HI/LO, registered output
module ex_alu_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [5:0]                funct,
  input  logic [DATA_WIDTH-1:0]     op_a,
  input  logic [DATA_WIDTH-1:0]     op_b,
  input  logic [4:0]                shamt,
  input  logic                      in_wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] in_wb_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     result,
  output logic                      out_wb_en,
  output logic [REG_ADDR_WIDTH-1:0] out_wb_addr,
  output logic                      busy
);

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                  state, state_next;
  logic [4:0]              cnt;
  logic [DATA_WIDTH-1:0]   mcand;
  logic [DATA_WIDTH-1:0]   hi, lo;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic [DATA_WIDTH-1:0]   a_mag, b_mag;
  logic [2*DATA_WIDTH-1:0] prod, prod_step, prod_final;
  logic [DATA_WIDTH:0]     step_sum;
  logic                    neg;
  logic                    accept, is_mul, is_mult_signed, mul_load;

  // Stalls ID while the multiplier runs or while MEM is holding off a full output register.
  assign in_ready       = (state == S_IDLE) && (!out_valid || out_ready) && !flush;
  assign accept         = in_valid && in_ready;
  assign is_mul         = (funct == F_MULT) || (funct == F_MULTU);
  assign is_mult_signed = (funct == F_MULT);
  assign mul_load       = (state == S_DONE) && (!out_valid || out_ready);
  assign busy           = (state != S_IDLE);

  // Signed multiply runs on magnitudes; the sign is reapplied when HI/LO are written.
  assign a_mag = (is_mult_signed && op_a[DATA_WIDTH-1]) ? -op_a : op_a;
  assign b_mag = (is_mult_signed && op_b[DATA_WIDTH-1]) ? -op_b : op_b;

  // Upper half accumulates the multiplicand when the current multiplier bit (LSB) is set, then the
  // whole product shifts right; the multiplier is consumed from the low half as the product fills in.
  assign step_sum   = {1'b0, prod[2*DATA_WIDTH-1:DATA_WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_step  = {step_sum, prod[DATA_WIDTH-1:1]};
  assign prod_final = neg ? -prod : prod;

  // Single-cycle result selection.
  always_comb begin
    alu_res = '0;
    case (funct)
      F_ADDU: alu_res = op_a + op_b;
      F_SUBU: alu_res = op_a - op_b;
      F_AND:  alu_res = op_a & op_b;
      F_OR:   alu_res = op_a | op_b;
      F_XOR:  alu_res = op_a ^ op_b;
      F_NOR:  alu_res = ~(op_a | op_b);
      F_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      F_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (op_a < op_b)};
      F_SLL:  alu_res = op_b << shamt;
      F_SRL:  alu_res = op_b >> shamt;
      F_SRA:  alu_res = $signed(op_b) >>> shamt;
      F_SLLV: alu_res = op_b << op_a[4:0];
      F_SRLV: alu_res = op_b >> op_a[4:0];
      F_SRAV: alu_res = $signed(op_b) >>> op_a[4:0];
      F_MFHI: alu_res = hi;
      F_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // Multiplier state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Multiplier next state: 32 BUSY iterations, then DONE until the output register is free.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept && is_mul) state_next = S_BUSY;
      S_BUSY: if (cnt == 5'd31)     state_next = S_DONE;
      S_DONE: if (mul_load)         state_next = S_IDLE;
      default:                      state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  // Multiplier operand capture and shift-add iteration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand <= '0;
      prod  <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
    end else if (accept && is_mul) begin
      mcand <= a_mag;
      prod  <= {{DATA_WIDTH{1'b0}}, b_mag};
      neg   <= is_mult_signed && (op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1]);
      cnt   <= '0;
    end else if (state == S_BUSY) begin
      prod  <= prod_step;
      cnt   <= cnt + 5'd1;
    end
  end

  // HI/LO update when the finished product retires; an aborted multiply leaves them untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (mul_load && !flush) begin
      {hi, lo} <= prod_final;
    end
  end

  // Output register: flush kills, multiply completion or ALU accept loads, a bare transfer drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      result      <= '0;
      out_wb_en   <= 1'b0;
      out_wb_addr <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
    end else if (mul_load) begin
      out_valid   <= 1'b1;
      result      <= '0;
      out_wb_en   <= 1'b0;
      out_wb_addr <= '0;
    end else if (accept && !is_mul) begin
      out_valid   <= 1'b1;
      result      <= alu_res;
      out_wb_en   <= in_wb_en;
      out_wb_addr <= in_wb_addr;
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// tb/tb_ex_alu_stage.sv - scoreboard bench for ex_alu_stage
`timescale 1ns/1ps
module tb_ex_alu_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  funct = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  shamt = '0;
  logic        in_wb_en = 1'b0;
  logic [4:0]  in_wb_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        out_wb_en;
  logic [4:0]  out_wb_addr;
  logic        busy;

  typedef struct packed {
    logic [31:0] res;
    logic        wb_en;
    logic [4:0]  addr;
  } exp_t;

  exp_t        sb[$];
  int unsigned xfer_cyc[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  ex_alu_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .op_a(op_a), .op_b(op_b), .shamt(shamt), .in_wb_en(in_wb_en),
    .in_wb_addr(in_wb_addr), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_wb_en(out_wb_en), .out_wb_addr(out_wb_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    logic [4:0] va;
    va = a[4:0];
    case (f)
      6'h21: return a + b;
      6'h23: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2B: return (a < b) ? 32'd1 : 32'd0;
      6'h00: return b << sh;
      6'h02: return b >> sh;
      6'h03: return $signed(b) >>> sh;
      6'h04: return b << va;
      6'h06: return b >> va;
      6'h07: return $signed(b) >>> va;
      default: return 32'd0;
    endcase
  endfunction

  // Output monitor: every transfer to MEM is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      xfer_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("result", result, e.res);
        check_eq("wb_en", {31'b0, out_wb_en}, {31'b0, e.wb_en});
        if (e.wb_en) check_eq("wb_addr", {27'b0, out_wb_addr}, {27'b0, e.addr});
      end
    end
  end

  // Presents one instruction, pushes its expectation at the accepting cycle; leaves in_valid high.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [4:0] wa, input exp_t e,
                       output int waited);
    funct = f; op_a = a; op_b = b; shamt = sh; in_wb_en = 1'b1; in_wb_addr = wa;
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check_eq("accept_timeout", {31'b0, in_ready}, 32'd1);
    else sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh, input logic [4:0] wa, output int waited);
    issue(f, a, b, sh, wa, {alu_model(f, a, b, sh), 1'b1, wa}, waited);
  endtask

  task automatic mult_run(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int w;
    int nb;
    int unsigned c0;
    issue(f, a, b, 5'd0, 5'd4, {32'h0, 1'b0, 5'd0}, w);
    in_valid = 1'b0;
    c0 = cyc;
    nb = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) break;
      if (busy) nb++;
    end
    check_eq("mul_latency", 32'(cyc - c0), 32'd33);
    check_eq("mul_busy_cycles", 32'(nb), 32'd33);
    @(posedge clk); #1;
    issue(6'h10, 32'h0, 32'h0, 5'd0, 5'd8, {exp_hi, 1'b1, 5'd8}, w);
    issue(6'h12, 32'h0, 32'h0, 5'd0, 5'd9, {exp_lo, 1'b1, 5'd9}, w);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] FUNCTS [15] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                                          6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h3F};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int w1, w2, w3;
    int nv;
    int unsigned c0;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_wb_en", {31'b0, out_wb_en}, 32'd0);
    check_eq("rst_wb_addr", {27'b0, out_wb_addr}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // back-to-back with MEM always ready
    xfer_cyc.delete();
    issue(6'h21, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0, 5'd1, {32'h0000_0001, 1'b1, 5'd1}, w1);
    c0 = cyc;
    issue(6'h2A, 32'h8000_0000, 32'h0000_0001, 5'd0, 5'd2, {32'h0000_0001, 1'b1, 5'd2}, w2);
    issue(6'h03, 32'h0, 32'hF000_0000, 5'd4, 5'd3, {32'hFF00_0000, 1'b1, 5'd3}, w3);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("b2b_no_stall", 32'(w1 + w2 + w3), 32'd0);
    check_eq("b2b_count", 32'(xfer_cyc.size()), 32'd3);
    if (xfer_cyc.size() == 3) begin
      check_eq("b2b_first", xfer_cyc[0], c0);
      check_eq("b2b_second", xfer_cyc[1], c0 + 1);
      check_eq("b2b_third", xfer_cyc[2], c0 + 2);
    end
    @(posedge clk); #1;

    // each ALU code with random operands, plus an undefined code
    for (int i = 0; i < 15; i++) begin
      ra = $urandom;
      rb = $urandom;
      alu(FUNCTS[i], ra, rb, 5'($urandom_range(0, 31)), 5'(i + 1), w);
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("alu_drained", 32'(sb.size()), 32'd0);

    // backpressure: result held, ID stalled, accept on the cycle MEM becomes ready
    out_ready = 1'b0;
    alu(6'h21, 32'h10, 32'h20, 5'd0, 5'd11, w);
    funct = 6'h26; op_a = 32'hA5A5_0000; op_b = 32'h0000_5A5A; in_wb_addr = 5'd12;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check_eq("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check_eq("bp_result", result, 32'h30);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    alu(6'h26, 32'hA5A5_0000, 32'h0000_5A5A, 5'd0, 5'd12, w);
    in_valid = 1'b0;
    check_eq("bp_accept_same_cycle", 32'(w), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    mult_run(6'h18, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    mult_run(6'h19, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA);
    mult_run(6'h18, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

    // asynchronous reset in the middle of a multiply
    issue(6'h18, 32'h7, 32'h9, 5'd0, 5'd4, {32'h0, 1'b0, 5'd0}, w);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    check_eq("mid_rst_busy", {31'b0, busy}, 32'd0);
    check_eq("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    issue(6'h10, 32'h0, 32'h0, 5'd0, 5'd13, {32'h0, 1'b1, 5'd13}, w);
    issue(6'h12, 32'h0, 32'h0, 5'd0, 5'd14, {32'h0, 1'b1, 5'd14}, w);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // flush an unsigned multiply at iteration 10
    issue(6'h19, 32'h0001_0000, 32'h0001_0000, 5'd0, 5'd4, {32'h0, 1'b0, 5'd0}, w);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_mul_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    void'(sb.pop_back());
    check_eq("flush_mul_idle", {31'b0, busy}, 32'd0);
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check_eq("flush_mul_no_output", 32'(nv), 32'd0);
    @(posedge clk); #1;
    issue(6'h10, 32'h0, 32'h0, 5'd0, 5'd15, {32'h0, 1'b1, 5'd15}, w);
    issue(6'h12, 32'h0, 32'h0, 5'd0, 5'd16, {32'h0, 1'b1, 5'd16}, w);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // flush with a held result and a pending instruction
    out_ready = 1'b0;
    issue(6'h21, 32'h1, 32'h1, 5'd0, 5'd17, {32'h2, 1'b1, 5'd17}, w);
    funct = 6'h21; op_a = 32'h5; op_b = 32'h5; in_wb_addr = 5'd18;
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_out_in_ready", {31'b0, in_ready}, 32'd0);
    check_eq("flush_out_valid_before", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check_eq("flush_out_valid_after", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
